// File: rtl/fir_tap_arbiter.sv
// fir_tap_arbiter: shares the single-port tap coefficient BRAM between the
// AXI-lite configuration path (cfg_*) and the FIR MAC engine (eng_*).
//
// Ports
//   axis_clk, axis_rst          clock, asynchronous active-high reset
//   ap_busy                     engine running; cfg writes are rejected while set
//   cfg_req/we/idx/wdata        cfg access request (held until cfg_gnt)
//   cfg_gnt                     cfg request accepted this cycle
//   cfg_rvalid/cfg_rdata        cfg read return, one cycle after the read grant
//   cfg_err                     one-cycle pulse after a rejected cfg write
//   eng_req/idx                 engine read request
//   eng_gnt                     engine read accepted this cycle
//   eng_rvalid/eng_rdata        engine read return, one cycle after the grant
//   tap_WE/EN/Di/A, tap_Do      BRAM port (1-cycle synchronous read)
module fir_tap_arbiter #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_busy,
  input  logic                   cfg_req,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_idx,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  output logic                   cfg_gnt,
  output logic                   cfg_rvalid,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  output logic                   cfg_err,
  input  logic                   eng_req,
  input  logic [3:0]             eng_idx,
  output logic                   eng_gnt,
  output logic                   eng_rvalid,
  output logic [pDATA_WIDTH-1:0] eng_rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  logic                   rd_vld_q,    rd_vld_d;
  logic                   rd_owner_q,  rd_owner_d;   // 1 = engine owns the in-flight read
  logic                   rd_zero_q,   rd_zero_d;    // in-flight read was out of range
  logic                   cfg_err_q,   cfg_err_d;
  logic [STV_W-1:0]       starve_q,    starve_d;
  logic [pDATA_WIDTH-1:0] cfg_rdata_q, cfg_rdata_d;
  logic [pDATA_WIDTH-1:0] eng_rdata_q, eng_rdata_d;

  logic                   cfg_in_rng_c;
  logic                   eng_in_rng_c;
  logic                   starved_c;
  logic [pDATA_WIDTH-1:0] ret_data_c;

  assign cfg_in_rng_c = 32'(cfg_idx) < Tape_Num;
  assign eng_in_rng_c = 32'(eng_idx) < Tape_Num;
  assign starved_c    = 32'(starve_q) >= STARVE_MAX;

  // Arbitration: cfg first while idle; engine first while busy, except that
  // cfg writes never touch the RAM when busy and a starved cfg read is forced.
  always_comb begin
    cfg_gnt = 1'b0;
    eng_gnt = 1'b0;
    if (!axis_rst) begin
      if (!ap_busy) begin
        if (cfg_req) cfg_gnt = 1'b1;
        else         eng_gnt = eng_req;
      end else begin
        if (cfg_req && (cfg_we || !eng_req || starved_c)) cfg_gnt = 1'b1;
        else                                              eng_gnt = eng_req;
      end
    end
  end

  // BRAM port drive for the granted access.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_Di = '0;
    tap_A  = '0;
    if (cfg_gnt) begin
      tap_A = pADDR_WIDTH'({cfg_idx, 2'b00});
      if (cfg_in_rng_c && !(cfg_we && ap_busy)) begin
        tap_EN = 1'b1;
        if (cfg_we) begin
          tap_WE = 4'hF;
          tap_Di = cfg_wdata;
        end
      end
    end else if (eng_gnt) begin
      tap_A  = pADDR_WIDTH'({eng_idx, 2'b00});
      tap_EN = eng_in_rng_c;
    end
  end

  // Out-of-range reads never enabled the RAM, so return 0 instead of tap_Do.
  assign ret_data_c = rd_zero_q ? '0 : tap_Do;

  assign cfg_rvalid = rd_vld_q && !rd_owner_q;
  assign eng_rvalid = rd_vld_q &&  rd_owner_q;
  assign cfg_rdata  = cfg_rvalid ? ret_data_c : cfg_rdata_q;
  assign eng_rdata  = eng_rvalid ? ret_data_c : eng_rdata_q;
  assign cfg_err    = cfg_err_q;

  // Next-state for read tracking, error pulse, starvation and data holds.
  always_comb begin
    rd_vld_d    = (cfg_gnt && !cfg_we) || eng_gnt;
    rd_owner_d  = eng_gnt;
    rd_zero_d   = cfg_gnt ? !cfg_in_rng_c : !eng_in_rng_c;
    cfg_err_d   = cfg_gnt && cfg_we && (ap_busy || !cfg_in_rng_c);
    cfg_rdata_d = cfg_rdata;
    eng_rdata_d = eng_rdata;
    starve_d    = starve_q;
    if (!cfg_req || cfg_gnt) starve_d = '0;
    else if (!starved_c)     starve_d = starve_q + STV_W'(1);
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rd_vld_q    <= 1'b0;
      rd_owner_q  <= 1'b0;
      rd_zero_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      starve_q    <= '0;
      cfg_rdata_q <= '0;
      eng_rdata_q <= '0;
    end else begin
      rd_vld_q    <= rd_vld_d;
      rd_owner_q  <= rd_owner_d;
      rd_zero_q   <= rd_zero_d;
      cfg_err_q   <= cfg_err_d;
      starve_q    <= starve_d;
      cfg_rdata_q <= cfg_rdata_d;
      eng_rdata_q <= eng_rdata_d;
    end
  end

endmodule

// File: doc/fir_tap_arbiter.md
Name: fir_tap_arbiter

Overview:
- Shares the single-port tap coefficient BRAM (bram11, 1-cycle synchronous read) between two requesters: the AXI-lite configuration path and the FIR compute engine.
- Enforces the ap_start/busy interlock: coefficients are writable only while the engine is not running.
- Sits between the fir AXI-lite slave logic, the MAC engine and the tap_RAM port group.

Parameters:
- pADDR_WIDTH, 12, BRAM byte-address width.
- pDATA_WIDTH, 32, coefficient width.
- Tape_Num, 11, number of valid taps (indices 0..Tape_Num-1).
- STARVE_MAX, 8, consecutive denied cfg cycles before cfg is forced a slot.

Ports:
- axis_clk  in  1  sole clock
- axis_rst  in  1  asynchronous, active-high reset
- ap_busy  in  1  engine running (from control FSM)
- cfg_req  in  1  cfg access request, held until cfg_gnt
- cfg_we  in  1  1=write, 0=read
- cfg_idx  in  4  tap index (AXI offset 0x20 already removed, divided by 4)
- cfg_wdata  in  32  write data
- cfg_gnt  out  1  request accepted this cycle
- cfg_rvalid  out  1  read data valid (1 cycle after read grant)
- cfg_rdata  out  32  read data
- cfg_err  out  1  1-cycle pulse: rejected write
- eng_req  in  1  engine read request
- eng_idx  in  4  tap index
- eng_gnt  out  1  engine read accepted this cycle
- eng_rvalid  out  1  engine data valid (1 cycle after grant)
- eng_rdata  out  32  engine data
- tap_WE  out  4  BRAM byte write enables
- tap_EN  out  1  BRAM enable
- tap_Di  out  32  BRAM write data
- tap_A  out  12  BRAM byte address = idx*4
- tap_Do  in  32  BRAM read data

Behaviour:
- Interface: one clock (axis_clk); reset (axis_rst) is asynchronous and active-high.
- Reset values: all grants, rvalids, cfg_err, tap_EN and tap_WE are 0; cfg_rdata and eng_rdata are 0; starvation counter and rd_owner are 0. Asserting reset mid-read discards the in-flight read: no rvalid follows it.
- Grant and BRAM drive are combinational from the current requests and registered state. At most one grant per cycle.
- ap_busy=0, priority is cfg > eng:
  - cfg read: tap_EN=1, tap_WE=0.
  - cfg write: tap_EN=1, tap_WE=4'hF, tap_Di=cfg_wdata.
- ap_busy=1, priority is eng > cfg:
  - cfg write: granted immediately; RAM untouched (tap_EN=0, tap_WE=0); cfg_err pulses in the cycle after the grant.
  - cfg read: granted only when eng_req=0, or when the starvation counter reaches STARVE_MAX. In the forced cycle cfg_gnt=1 and eng_gnt=0, so the engine retries the next cycle.
- Starvation counter:
  - Increments on each cycle with cfg_req=1 and cfg_gnt=0.
  - Clears on cfg_gnt or when cfg_req=0.
  - Saturates at STARVE_MAX.
- Read return:
  - rd_owner registers which requester was granted the read.
  - Next cycle: the matching rvalid=1 for exactly 1 cycle, and its rdata captures tap_Do. The rdata register holds until the next rvalid.
- Out-of-range index (idx >= Tape_Num):
  - No BRAM access (tap_EN=0).
  - A read is still granted and returns rdata=0 with the normal 1-cycle latency.
  - A cfg write is granted, dropped, and pulses cfg_err.
- Back-to-back: a new grant is allowed every cycle, including a grant in the same cycle as the previous read's rvalid.
- ap_busy toggling mid-transaction: the priority change takes effect on the next arbitration cycle. An in-flight read still returns to its recorded owner.
- tap_A = {idx, 2'b00} zero-extended to pADDR_WIDTH.
- Reads are not allowed to produce X: when tap_EN=0 for an out-of-range read, rdata is forced to 0.

Test Plan:
- ap_busy=0, cfg write idx1 = -10, then read idx1 -> cfg_gnt both cycles; cfg_rvalid the cycle after the read grant with cfg_rdata=32'hFFFF_FFF6; tap_A=12'h004.
- ap_busy=0, cfg_req and eng_req together (idx 5, idx 3) -> cfg_gnt=1, eng_gnt=0; eng granted next cycle; eng_rdata = coef[3] = 23.
- ap_busy=1, cfg write idx0 = 7 -> cfg_gnt=1, tap_WE=0, cfg_err pulses next cycle; later read idx0 returns the old value 0.
- ap_busy=1, eng_req held high continuously, cfg read idx5 -> cfg_gnt in the 9th cycle, eng_gnt=0 that cycle only; cfg_rdata=63.
- cfg read idx 11 -> tap_EN=0, cfg_rvalid next cycle with cfg_rdata=0; cfg write idx 12 -> cfg_err pulse.
- Assert axis_rst in the cycle after an eng read grant -> eng_rvalid never asserts; all outputs read 0 while reset is held.
